sprite_addr_gen: RTL

Parametrised, pipelined successor to the single-sprite VGA address generator. For every active VGA pixel it resolves which of NUM_SPR sprites covers (h_cnt, v_cnt), using fixed-index priority. It then emits the sprite-sheet ROM address, including an animation frame offset, plus a hit flag and sprite id.
- Sits between the VGA timing controller and the sprite block-memory read port.
- Its registered outputs line up with the ROM read latency.

---
 rtl/sprite_addr_gen_pkg.sv | 26 ++
 rtl/sprite_addr_gen_if.sv | 30 +++
 rtl/sprite_addr_gen_hit_calc.sv | 47 ++++
 rtl/sprite_addr_gen.sv | 139 +++++++++++++
 4 files changed

// File: rtl/sprite_addr_gen_pkg.sv
// Shared constants and sprite-sheet address helpers for the sprite address generator.
package sprite_pkg;

    localparam int SPR_W_DEF   = 20;
    localparam int SPR_H_DEF   = 20;
    localparam int FRAMES_DEF  = 4;
    localparam int SPR_ID_W    = 3;

    function automatic int unsigned spr_pix(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    function automatic int unsigned sheet_stride(input int unsigned frames, input int unsigned w,
                                                 input int unsigned h);
        return frames * spr_pix(w, h);
    endfunction

    // Each sprite owns FRAMES consecutive frames of w*h pixels in the sheet.
    function automatic logic [31:0] sheet_addr(input int unsigned id, input int unsigned frame,
                                               input int unsigned frames, input int unsigned w,
                                               input int unsigned h, input int unsigned dx,
                                               input int unsigned dy);
        return id * sheet_stride(frames, w, h) + frame * spr_pix(w, h) + dy * w + dx;
    endfunction

endpackage

// File: rtl/sprite_addr_gen_if.sv
// Pixel-side bus between VGA timing, the address generator and the sprite ROM.
interface sprite_addr_gen_if
    import sprite_pkg::*;
#(
    parameter int NUM_SPR = 4,
    parameter int ADDR_W  = 17
);
    logic [9:0]            h_cnt;
    logic [9:0]            v_cnt;
    logic                  pix_valid;
    logic                  frame_tick;
    logic [10*NUM_SPR-1:0] pos_h;
    logic [10*NUM_SPR-1:0] pos_v;
    logic [NUM_SPR-1:0]    spr_en;
    logic [NUM_SPR-1:0]    anim_en;
    logic [ADDR_W-1:0]     pixel_addr;
    logic                  hit;
    logic [SPR_ID_W-1:0]   spr_id;
    logic                  out_valid;

    modport master (
        output h_cnt, v_cnt, pix_valid, frame_tick, pos_h, pos_v, spr_en, anim_en,
        input  pixel_addr, hit, spr_id, out_valid
    );

    modport slave (
        input  h_cnt, v_cnt, pix_valid, frame_tick, pos_h, pos_v, spr_en, anim_en,
        output pixel_addr, hit, spr_id, out_valid
    );
endinterface

// File: rtl/sprite_addr_gen_hit_calc.sv
// Single-channel stage-1 unit: coverage test and in-sprite offsets, registered.
module sprite_hit_calc #(
    parameter int SPR_W = 20,
    parameter int SPR_H = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_cnt_i,
    input  logic [9:0]  v_cnt_i,
    input  logic [9:0]  pos_h_i,
    input  logic [9:0]  pos_v_i,
    input  logic        en_i,
    input  logic        pix_valid_i,
    output logic        in_o,
    output logic [10:0] dx_o,
    output logic [10:0] dy_o
);
    logic        in_d, in_p1_q;
    logic [10:0] dx_d, dy_d, dx_p1_q, dy_p1_q;

    // The >= terms stop pixels left/above the origin from wrapping into range.
    always_comb begin
        dx_d = {1'b0, h_cnt_i} - {1'b0, pos_h_i};
        dy_d = {1'b0, v_cnt_i} - {1'b0, pos_v_i};
        in_d = en_i & pix_valid_i
             & (h_cnt_i >= pos_h_i) & (dx_d < 11'(SPR_W))
             & (v_cnt_i >= pos_v_i) & (dy_d < 11'(SPR_H));
    end

    // stage 1 -> stage 2 boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            in_p1_q <= 1'b0;
        end else begin
            in_p1_q <= in_d;
        end
    end

    always_ff @(posedge clk) begin
        dx_p1_q <= dx_d;
        dy_p1_q <= dy_d;
    end

    assign in_o = in_p1_q;
    assign dx_o = dx_p1_q;
    assign dy_o = dy_p1_q;
endmodule

// File: rtl/sprite_addr_gen.sv
// Multi-sprite VGA address generator: shadowed positions, animation frames, 2-cycle pipeline.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int SPR_W     = SPR_W_DEF,
    parameter int SPR_H     = SPR_H_DEF,
    parameter int NUM_SPR   = 4,
    parameter int FRAMES    = FRAMES_DEF,
    parameter int FRAME_DIV = 8,
    parameter int ADDR_W    = 17
) (
    input logic             clk,
    input logic             rst,
    sprite_addr_gen_if.slave bus
);
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int FR_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic [10*NUM_SPR-1:0] pos_h_q, pos_v_q;
    logic [NUM_SPR-1:0]    en_q;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [FR_W-1:0]       frame_q [NUM_SPR];
    logic [FR_W-1:0]       frame_d [NUM_SPR];

    logic [NUM_SPR-1:0]    in_p1;
    logic [10:0]           dx_p1 [NUM_SPR];
    logic [10:0]           dy_p1 [NUM_SPR];
    logic                  vld_p1_q, vld_p2_q;

    logic                  sel_hit;
    logic [SPR_ID_W-1:0]   sel_id;
    logic [FR_W-1:0]       sel_frame;
    logic [10:0]           sel_dx, sel_dy;
    logic [ADDR_W-1:0]     addr_d, addr_p2_q;
    logic                  hit_p2_q;
    logic [SPR_ID_W-1:0]   id_p2_q;

    // Shadows only move on frame_tick so a frame is always drawn from one consistent set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_h_q <= '0;
            pos_v_q <= '0;
            en_q    <= '0;
        end else if (bus.frame_tick) begin
            pos_h_q <= bus.pos_h;
            pos_v_q <= bus.pos_v;
            en_q    <= bus.spr_en;
        end
    end

    always_comb begin
        div_d   = div_q;
        frame_d = frame_q;
        if (bus.frame_tick) begin
            if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                div_d = '0;
                for (int i = 0; i < NUM_SPR; i++) begin
                    if (bus.anim_en[i]) begin
                        frame_d[i] = (FRAMES > 1) ? frame_q[i] + 1'b1 : '0;
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            for (int i = 0; i < NUM_SPR; i++) frame_q[i] <= '0;
        end else begin
            div_q   <= div_d;
            frame_q <= frame_d;
        end
    end

    // stage 0 -> stage 1 boundary
    for (genvar g = 0; g < NUM_SPR; g++) begin : g_hit
        sprite_hit_calc #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
            .clk        (clk),
            .rst        (rst),
            .h_cnt_i    (bus.h_cnt),
            .v_cnt_i    (bus.v_cnt),
            .pos_h_i    (pos_h_q[10*g +: 10]),
            .pos_v_i    (pos_v_q[10*g +: 10]),
            .en_i       (en_q[g]),
            .pix_valid_i(bus.pix_valid),
            .in_o       (in_p1[g]),
            .dx_o       (dx_p1[g]),
            .dy_o       (dy_p1[g])
        );
    end

    // Walk from highest to lowest index so the lowest hitting sprite is assigned last.
    always_comb begin
        sel_hit   = 1'b0;
        sel_id    = '0;
        sel_frame = '0;
        sel_dx    = '0;
        sel_dy    = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (in_p1[i]) begin
                sel_hit   = 1'b1;
                sel_id    = SPR_ID_W'(i);
                sel_frame = frame_q[i];
                sel_dx    = dx_p1[i];
                sel_dy    = dy_p1[i];
            end
        end
        addr_d = '0;
        if (sel_hit) begin
            addr_d = ADDR_W'(sheet_addr(32'(sel_id), 32'(sel_frame), FRAMES, SPR_W, SPR_H,
                                        32'(sel_dx), 32'(sel_dy)));
        end
    end

    // stage 1 -> stage 2 boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            addr_p2_q <= '0;
            hit_p2_q  <= 1'b0;
            id_p2_q   <= '0;
        end else begin
            vld_p1_q  <= bus.pix_valid;
            vld_p2_q  <= vld_p1_q;
            addr_p2_q <= addr_d;
            hit_p2_q  <= sel_hit;
            id_p2_q   <= sel_hit ? sel_id : '0;
        end
    end

    assign bus.pixel_addr = addr_p2_q;
    assign bus.hit        = hit_p2_q;
    assign bus.spr_id     = id_p2_q;
    assign bus.out_valid  = vld_p2_q;
endmodule
